// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result bus for the pipelined logic unit.
//   master: operand source + result sink (drives in_*, out_ready, acc_clr)
//   slave : the logic unit (drives in_ready, out_*, acc_q, txn_cnt)
//   in_*      operands, opcode, accumulator controls, valid/ready
//   out_*     result, flags, valid/ready
//   acc_clr   accumulator clear, independent of the handshake
//   acc_q     accumulator value, txn_cnt accepted-transaction counter
interface logic_unit_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_use_acc;
  logic             in_acc_wr;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic             out_illegal;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] txn_cnt;

  modport master (
    output in_valid, in_a, in_b, in_op, in_use_acc, in_acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_parity, out_illegal, acc_q, txn_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_use_acc, in_acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_parity, out_illegal, acc_q, txn_cnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: elastic, pipelined WIDTH-bit logic unit with accumulator
// operand source, result flags and an accepted-transaction counter.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    logic_unit_pipe_if.slave (operands in, result + flags out,
//          accumulator and counter status)
// The result and its flags are formed combinationally at accept and ride
// through STAGES identical register stages; only stage 1 sees new data.

// One pipeline register stage: loads valid + payload whenever it may advance,
// otherwise holds (which keeps the output stable under backpressure).
module logic_unit_pipe_stage #(
  parameter int PW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          vld_d,
  input  logic [PW-1:0] dat_d,
  output logic          vld_q,
  output logic [PW-1:0] dat_q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
endmodule

module logic_unit_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_unit_pipe_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             illegal;
  } res_t;

  localparam int PW = $bits(res_t);

  // Index 0 is the input side (offered valid / freshly computed result);
  // index i is the output of register stage i.
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][PW-1:0] dat_pipe;
  logic [STAGES:1]         adv;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opb;
  logic [CNT_W-1:0] txn_cnt;
  logic             accept;
  res_t             res;
  res_t             out_r;

  assign accept = bus.in_valid && adv[1];

  // Result and flags at accept; accumulator is the pre-update value.
  always_comb begin
    opb = bus.in_use_acc ? acc_q : bus.in_b;
    res = '0;
    case (bus.in_op)
      3'b000:  res.y = bus.in_a & opb;
      3'b001:  res.y = ~(bus.in_a & opb);
      3'b010:  res.y = bus.in_a | opb;
      3'b011:  res.y = ~(bus.in_a | opb);
      3'b100:  res.y = bus.in_a ^ opb;
      3'b101:  res.y = ~(bus.in_a ^ opb);
      3'b110:  res.y = ~bus.in_a;
      default: res.illegal = 1'b1;
    endcase
    res.zero   = ~|res.y;
    res.parity = ^res.y;
  end

  assign vld_pipe[0] = bus.in_valid;
  assign dat_pipe[0] = res;

  // adv[i] = !v[i] || adv[i+1] unrolled: a stage may move if the output is
  // being taken or any stage from i to the end holds a bubble.
  for (genvar i = 1; i <= STAGES; i++) begin : g_stg
    assign adv[i] = bus.out_ready | ~(&vld_pipe[STAGES:i]);

    logic_unit_pipe_stage #(.PW(PW)) u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv[i]),
      .vld_d (vld_pipe[i-1]),
      .dat_d (dat_pipe[i-1]),
      .vld_q (vld_pipe[i]),
      .dat_q (dat_pipe[i])
    );
  end

  // A write at accept makes back-to-back accumulator chains hazard-free;
  // an accepted write takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      txn_cnt <= '0;
    end else begin
      if (accept && bus.in_acc_wr) acc_q <= res.y;
      else if (bus.acc_clr)        acc_q <= '0;
      if (accept) txn_cnt <= txn_cnt + 1'b1;
    end
  end

  assign out_r           = dat_pipe[STAGES];
  assign bus.in_ready    = adv[1];
  assign bus.out_valid   = vld_pipe[STAGES];
  assign bus.out_y       = out_r.y;
  assign bus.out_zero    = out_r.zero;
  assign bus.out_parity  = out_r.parity;
  assign bus.out_illegal = out_r.illegal;
  assign bus.acc_q       = acc_q;
  assign bus.txn_cnt     = txn_cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed checks of logic_unit_pipe on three builds
// sharing one stimulus: S=1/CNT_W=4 (b1), S=2 (b2), S=3 (b3).
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_use_acc = 1'b0, in_acc_wr = 1'b0;
  logic       acc_clr = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;

  logic_unit_pipe_if #(.WIDTH(4), .CNT_W(4))  b1 ();
  logic_unit_pipe_if #(.WIDTH(4), .CNT_W(16)) b2 ();
  logic_unit_pipe_if #(.WIDTH(4), .CNT_W(16)) b3 ();

  assign b1.in_valid = in_valid;  assign b2.in_valid = in_valid;  assign b3.in_valid = in_valid;
  assign b1.in_a = in_a;          assign b2.in_a = in_a;          assign b3.in_a = in_a;
  assign b1.in_b = in_b;          assign b2.in_b = in_b;          assign b3.in_b = in_b;
  assign b1.in_op = in_op;        assign b2.in_op = in_op;        assign b3.in_op = in_op;
  assign b1.in_use_acc = in_use_acc; assign b2.in_use_acc = in_use_acc; assign b3.in_use_acc = in_use_acc;
  assign b1.in_acc_wr = in_acc_wr;   assign b2.in_acc_wr = in_acc_wr;   assign b3.in_acc_wr = in_acc_wr;
  assign b1.acc_clr = acc_clr;    assign b2.acc_clr = acc_clr;    assign b3.acc_clr = acc_clr;
  assign b1.out_ready = out_ready; assign b2.out_ready = out_ready; assign b3.out_ready = out_ready;

  logic_unit_pipe #(.WIDTH(4), .STAGES(1), .CNT_W(4))  u_s1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic_unit_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(16)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic_unit_pipe #(.WIDTH(4), .STAGES(3), .CNT_W(16)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; in_acc_wr = 1'b0; in_use_acc = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] ref_y(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: ref_y = a & b;
      3'd1: ref_y = ~(a & b);
      3'd2: ref_y = a | b;
      3'd3: ref_y = ~(a | b);
      3'd4: ref_y = a ^ b;
      3'd5: ref_y = ~(a ^ b);
      3'd6: ref_y = ~a;
      default: ref_y = 4'h0;
    endcase
  endfunction

  // A=1100, B=1010 for ops 0..7; flags are {zero, parity, illegal}
  logic [3:0] exp_y [8] = '{4'h8, 4'h7, 4'hE, 4'h1, 4'h6, 4'h9, 4'h3, 4'h0};
  logic [2:0] exp_f [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b101};

  logic [3:0] sbq [$];
  int idx, n_acc;
  logic took;

  initial begin
    // reset state
    do_rst();
    chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_out_y", 32'(b1.out_y), 32'd0);
    chk("rst_flags", 32'({b1.out_zero, b1.out_parity, b1.out_illegal}), 32'd0);
    chk("rst_acc", 32'(b1.acc_q), 32'd0);
    chk("rst_cnt", 32'(b1.txn_cnt), 32'd0);
    chk("rst_in_ready", 32'(b1.in_ready), 32'd1);

    // 1: every opcode back-to-back on S=1
    in_a = 4'b1100; in_b = 4'b1010; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      tick();
      chk($sformatf("t1_valid_op%0d", i), 32'(b1.out_valid), 32'd1);
      chk($sformatf("t1_y_op%0d", i), 32'(b1.out_y), 32'(exp_y[i]));
      chk($sformatf("t1_flags_op%0d", i), 32'({b1.out_zero, b1.out_parity, b1.out_illegal}), 32'(exp_f[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_drained", 32'(b1.out_valid), 32'd0);
    chk("t1_cnt", 32'(b1.txn_cnt), 32'd8);

    // 2: S=3 backpressure, ordering and hold
    do_rst();
    in_valid = 1'b1; in_op = 3'b010; in_b = 4'h0; out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = 4'(idx + 1);
      #1 took = b3.in_ready;
      tick();
      if (took) idx++;
    end
    chk("t2_accepted", 32'(idx), 32'd3);
    chk("t2_full_ready", 32'(b3.in_ready), 32'd0);
    chk("t2_head_valid", 32'(b3.out_valid), 32'd1);
    chk("t2_head_y", 32'(b3.out_y), 32'd1);
    tick();
    chk("t2_hold_y", 32'(b3.out_y), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("t2_ready_on_drain", 32'(b3.in_ready), 32'd1);
    tick();
    chk("t2_y2", 32'(b3.out_y), 32'd2);
    chk("t2_cnt", 32'(b3.txn_cnt), 32'd4);
    in_valid = 1'b0;
    tick();
    chk("t2_y3", 32'(b3.out_y), 32'd3);
    tick();
    chk("t2_y4", 32'(b3.out_y), 32'd4);
    chk("t2_y4_valid", 32'(b3.out_valid), 32'd1);
    tick();
    chk("t2_empty", 32'(b3.out_valid), 32'd0);

    // 3: accumulator chain on S=1
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("t3_clr", 32'(b1.acc_q), 32'd0);
    in_valid = 1'b1; in_op = 3'b010; in_a = 4'b0001; in_b = 4'b0000; in_acc_wr = 1'b1; in_use_acc = 1'b0;
    tick();
    chk("t3_y1", 32'(b1.out_y), 32'h1);
    chk("t3_acc1", 32'(b1.acc_q), 32'h1);
    in_a = 4'b0010; in_b = 4'b1000; in_use_acc = 1'b1;
    tick();
    chk("t3_y2", 32'(b1.out_y), 32'h3);
    in_op = 3'b100; in_a = 4'b1111;
    tick();
    chk("t3_y3", 32'(b1.out_y), 32'hC);
    chk("t3_acc3", 32'(b1.acc_q), 32'hC);

    // 4: accepted write beats clear; clear alone zeroes
    in_op = 3'b000; in_a = 4'b0111; in_b = 4'b1101; in_use_acc = 1'b0; acc_clr = 1'b1;
    tick();
    chk("t4_write_wins", 32'(b1.acc_q), 32'h5);
    in_valid = 1'b0; in_acc_wr = 1'b0;
    tick();
    acc_clr = 1'b0;
    chk("t4_clr_alone", 32'(b1.acc_q), 32'h0);

    // 5: reset with two results in flight on S=2
    do_rst();
    in_valid = 1'b1; in_op = 3'b010; in_a = 4'h5; in_b = 4'h0; in_acc_wr = 1'b1; out_ready = 1'b0;
    tick(); tick();
    in_valid = 1'b0; in_acc_wr = 1'b0;
    chk("t5_pre_valid", 32'(b2.out_valid), 32'd1);
    chk("t5_pre_acc", 32'(b2.acc_q), 32'h5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_valid", 32'(b2.out_valid), 32'd0);
    chk("t5_acc", 32'(b2.acc_q), 32'd0);
    chk("t5_cnt", 32'(b2.txn_cnt), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_stale", 32'(b2.out_valid), 32'd0);
    end

    // 6: random valid/ready on S=1, 17 accepts, counter wrap
    do_rst();
    n_acc = 0;
    sbq.delete();
    for (int c = 0; c < 400 && n_acc < 17; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_a  = 4'($urandom_range(0, 15));
      in_b  = 4'($urandom_range(0, 15));
      in_op = 3'($urandom_range(0, 7));
      #1;
      if (b1.out_valid && out_ready) begin
        if (sbq.size() == 0) chk("t6_spurious", 32'd1, 32'd0);
        else chk("t6_order", 32'(b1.out_y), 32'(sbq.pop_front()));
      end
      if (in_valid && b1.in_ready) begin
        sbq.push_back(ref_y(in_op, in_a, in_b));
        n_acc++;
      end
      tick();
    end
    chk("t6_accepted", 32'(n_acc), 32'd17);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (b1.out_valid) begin
        if (sbq.size() == 0) chk("t6_spurious", 32'd1, 32'd0);
        else chk("t6_order", 32'(b1.out_y), 32'(sbq.pop_front()));
      end
      tick();
    end
    chk("t6_sb_empty", 32'(sbq.size()), 32'd0);
    chk("t6_cnt_wrap", 32'(b1.txn_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
